// File: rtl/arbiter_n2_master_pkg.sv
// Shared types for the 2-way arbiter requester front end: request/grant buses,
// FSM states, error flag indices and the request encoder.
package arbiter_n2_master_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'b00,
    REQ0   = 2'b01,
    REQ1   = 2'b10,
    REQ01  = 2'b11
  } req_t;

  typedef enum logic [1:0] {
    NO_GNT  = 2'b00,
    GNT0    = 2'b01,
    GNT1    = 2'b10,
    GNT_ILL = 2'b11
  } gnt_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    STATE_GNT0 = 2'b01,
    STATE_GNT1 = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_GNT_LOST    = 2'd0,
    ERR_GNT_ILLEGAL = 2'd1,
    ERR_OVERRUN     = 2'd2
  } err_idx_e;

  function automatic req_t encode_req(input logic r0, input logic r1);
    return req_t'({r1, r0});
  endfunction

endpackage

// File: rtl/arbiter_n2_master.sv
// Two-client burst front end: 0-cycle data pass-through, grant registered into state (1 cycle to first beat).
// Backpressure: out_ready passes straight to the granted client; a missing/mismatched grant stalls both clients.
module arbiter_n2_master
  import arbiter_n2_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_valid,
  output logic              c0_ready,
  input  logic [DATA_W-1:0] c0_data,
  input  logic              c0_last,
  input  logic              c1_valid,
  output logic              c1_ready,
  input  logic [DATA_W-1:0] c1_data,
  input  logic              c1_last,
  output req_t              req_o,
  input  gnt_t              gnt_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  output logic [2:0]        err_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic             fwd0, fwd1, hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Lock term keeps the request asserted through client bubbles mid-burst.
  assign req_o = encode_req(c0_valid | (state_q == STATE_GNT0),
                            c1_valid | (state_q == STATE_GNT1));
  assign err_o = err_q;

  assign fwd0 = (state_q == STATE_GNT0) && (gnt_i == GNT0);
  assign fwd1 = (state_q == STATE_GNT1) && (gnt_i == GNT1);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = 1'b0;
    c0_ready  = 1'b0;
    c1_ready  = 1'b0;
    if (fwd0) begin
      out_valid = c0_valid;
      out_data  = c0_data;
      out_last  = c0_last;
      c0_ready  = out_ready;
    end else if (fwd1) begin
      out_valid = c1_valid;
      out_data  = c1_data;
      out_last  = c1_last;
      out_src   = 1'b1;
      c1_ready  = out_ready;
    end
    hs = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (gnt_i == GNT_ILL) err_d[ERR_GNT_ILLEGAL] = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_i == GNT0 && c0_valid)      state_d = STATE_GNT0;
        else if (gnt_i == GNT1 && c1_valid) state_d = STATE_GNT1;
      end
      STATE_GNT0, STATE_GNT1: begin
        if (!fwd0 && !fwd1) err_d[ERR_GNT_LOST] = 1'b1;
        if (hs) begin
          if (out_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            // Overrun is flagged but forwarding continues; the counter saturates.
            if (cnt_q == CNT_LAST) err_d[ERR_OVERRUN] = 1'b1;
            if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/arbiter_n2_master.md
# arbiter_n2_master

Requester-side front end for the 2-way arbiter. Collects bursts from two local clients, encodes their pending requests onto the arbiter request bus, consumes the returned grant and forwards the granted client's burst beat by beat onto one shared downstream valid/ready channel. The request stays locked until the last beat is accepted. The block sits between the two client sources and the arbitrated shared resource, facing the arbiter across `req_t`/`gnt_t`.

## Interface
Parameters:
- `DATA_W`, 32, width of client and output data
- `MAX_BEATS`, 16, longest legal burst; the beat counter is `$clog2(MAX_BEATS+1)` bits

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `c0_valid` / `c1_valid` input 1: client beat valid.
- `c0_ready` / `c1_ready` output 1: client beat accepted.
- `c0_data` / `c1_data` input `DATA_W`: client beat data.
- `c0_last` / `c1_last` input 1: final beat of the burst.
- `req_o` output `req_t`: request bus to the arbiter.
- `gnt_i` input `gnt_t`: grant from the arbiter.
- `out_valid` output 1: shared channel beat valid.
- `out_ready` input 1: shared channel beat accepted.
- `out_data` output `DATA_W`: forwarded beat data.
- `out_last` output 1: forwarded last flag.
- `out_src` output 1: source client of the current beat (0/1).
- `err_o` output 3: sticky error flags.

## Operation
- **FSM** uses `state_t`:
  - `IDLE` → `STATE_GNT0` when `gnt_i==GNT0 && c0_valid`.
  - `IDLE` → `STATE_GNT1` when `gnt_i==GNT1 && c1_valid`.
  - `STATE_GNTk` → `IDLE` on the output handshake (`out_valid && out_ready`) with `ck_last`.
- **Request encoding:**
  - `reqk = ck_valid | (state==STATE_GNTk)`.
  - `req_o` = NO_REQ / REQ0 / REQ1 / REQ01 from `{req1, req0}`.
  - The lock term holds the request through client bubbles mid-burst.
- **Datapath:**
  - In `STATE_GNTk` with `gnt_i==GNTk`: `out_valid=ck_valid`, `out_data=ck_data`, `out_last=ck_last`, `out_src=k`, `ck_ready=out_ready`.
  - The other client's ready is 0.
  - In `IDLE`, or when the grant does not match: `out_valid=0` and both readies are 0 (stall, no beat lost).
- **Beat counter:**
  - Cleared in `IDLE`.
  - Increments on each output handshake in `STATE_GNTx`, saturating at `MAX_BEATS`.
- **`err_o`** bits set on the failing cycle and clear only on reset:
  - [0] grant lost: `gnt_i != GNTk` while in `STATE_GNTk`. The transfer stalls and resumes if the grant returns.
  - [1] illegal `gnt_i` encoding 2'b11. It is treated as NO_GNT.
  - [2] overrun: a handshake without last when the counter is already `MAX_BEATS-1`. Forwarding continues.
- **Stale grant:** `gnt_i==GNTk` in `IDLE` with `ck_valid=0` → stay `IDLE`, no error.

## Timing
- **Reset values:** state `IDLE`, beat counter 0, `err_o` 3'b000. With clients idle, `req_o`=NO_REQ, `out_valid`=0, both readies 0.
- **Request latency:** `req_o` is combinational from `ck_valid`, so it asserts the same cycle as the first valid.
- **Grant-to-first-beat:** 1 cycle. The grant is registered into the state, and the first handshake can occur the cycle after `gnt_i` arrives.
- **Data path latency:** 0 cycles (combinational pass-through).
- **Back-to-back bursts:**
  - Last-beat handshake at cycle N → `IDLE` at N+1.
  - If `ck_valid` is still high, the request never drops, and a re-grant at N+1 gives the first beat at N+2.
- **Single-beat burst:** a first beat with `last` at N+1 returns the block to `IDLE` at N+2.
- **Simultaneous** `c0_valid` and `c1_valid` drive REQ01, and the grant alone selects the winner.
- **Reset mid-burst:** the block returns to `IDLE` immediately. The partially sent burst is abandoned and clients must re-issue.

## Structure
- The shared package holds `req_t`, `gnt_t`, `state_t`, plus a new `err_idx_e` enum (ERR_GNT_LOST=0, ERR_GNT_ILLEGAL=1, ERR_OVERRUN=2).
- Single flat module, no sub-module. The combinational `req_t` encode is a package function `encode_req(logic r0, logic r1)`.

## Test plan
- **Reset then idle:** all outputs at reset values, `req_o`=NO_REQ, `err_o`=0.
- **Client 0 three-beat burst** (data 0xA,0xB,0xC), GNT0 held, `out_ready`=1:
  - `req_o`=REQ0 in cycle 0.
  - Beats at cycles 2,3,4 with `out_src`=0.
  - `IDLE` at 5, `req_o`=NO_REQ.
- **Both clients valid, `out_ready` toggling 1/0:**
  - `req_o`=REQ01.
  - GNT1 → only client 1 beats, and none are lost during ready-low cycles.
  - Then GNT0 → client 0 burst.
- **Grant drop mid-burst:** `gnt_i` goes GNT0 → NO_GNT after beat 1 → `out_valid`=0 and `err_o[0]`=1. The grant returns → the remaining beats complete.
- **Illegal and stale grants:**
  - `gnt_i`=2'b11 → `err_o[1]`=1, no state change.
  - GNT1 with `c1_valid`=0 → stays `IDLE`.
- **Overrun:** `MAX_BEATS`=16 and a 17-beat burst → `err_o[2]` sets on the 16th handshake, and all 17 beats are forwarded.
